// File: rtl/regbank_auto_pkg.sv
// Shared types and the address decode for the auto-advancing register bank.
package regbank_auto_pkg;

   // Widest data register supported; cells store their value at this width.
   localparam int MAX_DATA_W = 64;

   typedef enum logic [1:0] {
      MODE_HOLD   = 2'd0,
      MODE_INC    = 2'd1,
      MODE_DEC    = 2'd2,
      MODE_TOGGLE = 2'd3
   } reg_mode_e;

   // One data register plus its mode. Bits of value above the bank's DATA_W stay zero.
   typedef struct packed {
      reg_mode_e               mode;
      logic [MAX_DATA_W-1:0]   value;
   } reg_cell_s;

   typedef enum logic [1:0] {
      ADDR_DATA = 2'd0,
      ADDR_MODE = 2'd1,
      ADDR_ERR  = 2'd2
   } addr_kind_e;

   // Data registers occupy 0..num_regs-1, mode registers the next num_regs addresses.
   function automatic addr_kind_e decode_kind(input int unsigned addr, input int unsigned num_regs);
      if (addr < num_regs)
         return ADDR_DATA;
      else if (addr < 2 * num_regs)
         return ADDR_MODE;
      else
         return ADDR_ERR;
   endfunction

   // Register index targeted by an address; meaningless when the kind is ADDR_ERR.
   function automatic int unsigned decode_index(input int unsigned addr, input int unsigned num_regs);
      if (addr < num_regs)
         return addr;
      else
         return addr - num_regs;
   endfunction

endpackage

// File: rtl/regbank_cell.sv
// One data register with its mode register; advances on tick and flags wraps.
module regbank_cell
   import regbank_auto_pkg::*;
#(
   parameter int          DATA_W = 32,
   parameter int unsigned STEP   = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              wr_value_en,
   input  logic [DATA_W-1:0] wr_value,
   input  logic              wr_mode_en,
   input  reg_mode_e         wr_mode,
   input  logic              tick,
   output logic [DATA_W-1:0] value,
   output reg_mode_e         mode,
   output logic              wrap
);

   // Arithmetic runs at the full storage width and is masked back to DATA_W bits.
   localparam logic [MAX_DATA_W-1:0] VALUE_MASK = {MAX_DATA_W{1'b1}} >> (MAX_DATA_W - DATA_W);
   localparam logic [MAX_DATA_W-1:0] STEP_VAL   = MAX_DATA_W'(STEP) & VALUE_MASK;
   localparam logic [MAX_DATA_W:0]   CARRY_BIT  = {{MAX_DATA_W{1'b0}}, 1'b1} << DATA_W;

   reg_cell_s               cell_reg, cell_next;
   logic                    wrap_reg, wrap_next;
   logic [MAX_DATA_W:0]     sum;
   logic [MAX_DATA_W-1:0]   diff;

   // Next state: a value write beats the tick; the tick always uses the current mode.
   always_comb begin
      sum       = {1'b0, cell_reg.value} + {1'b0, STEP_VAL};
      diff      = cell_reg.value - STEP_VAL;
      cell_next = cell_reg;
      wrap_next = 1'b0;
      if (wr_value_en) begin
         cell_next.value = MAX_DATA_W'(wr_value);
      end else if (tick) begin
         case (cell_reg.mode)
            MODE_INC: begin
               cell_next.value = sum[MAX_DATA_W-1:0] & VALUE_MASK;
               wrap_next       = |(sum & CARRY_BIT);
            end
            MODE_DEC: begin
               cell_next.value = diff & VALUE_MASK;
               wrap_next       = (cell_reg.value < STEP_VAL);
            end
            MODE_TOGGLE: cell_next.value = ~cell_reg.value & VALUE_MASK;
            default: ;
         endcase
      end
      if (wr_mode_en)
         cell_next.mode = wr_mode;
   end

   // State flops; reset overrides any same-cycle write or tick.
   always_ff @(posedge clock) begin
      if (reset) begin
         cell_reg <= '{mode: MODE_HOLD, value: '0};
         wrap_reg <= 1'b0;
      end else begin
         cell_reg <= cell_next;
         wrap_reg <= wrap_next;
      end
   end

   assign value = cell_reg.value[DATA_W-1:0];
   assign mode  = cell_reg.mode;
   assign wrap  = wrap_reg;

endmodule

// File: rtl/regbank_auto.sv
// Bank of auto-advancing registers with bus write/read ports and a flat status export.
module regbank_auto
   import regbank_auto_pkg::*;
#(
   parameter int          NUM_REGS = 2,
   parameter int          DATA_W   = 32,
   parameter int          ADDR_W   = 3,
   parameter int unsigned STEP     = 1
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       wr_en,
   input  logic [ADDR_W-1:0]          wr_addr,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic                       rd_en,
   input  logic [ADDR_W-1:0]          rd_addr,
   output logic                       rd_valid,
   output logic [DATA_W-1:0]          rd_data,
   output logic                       rd_err,
   input  logic                       tick,
   output logic [NUM_REGS-1:0]        wrap,
   output logic [NUM_REGS*DATA_W-1:0] regs_flat
);

   logic [DATA_W-1:0] value_arr [NUM_REGS];
   reg_mode_e         mode_arr  [NUM_REGS];

   addr_kind_e        wr_kind, rd_kind;
   int unsigned       wr_idx, rd_idx;
   logic [DATA_W-1:0] rd_sel;

   logic              rd_valid_reg;
   logic [DATA_W-1:0] rd_data_reg;
   logic              rd_err_reg;

   // Decode both bus addresses into kind and register index.
   always_comb begin
      wr_kind = decode_kind(32'(wr_addr), NUM_REGS);
      wr_idx  = decode_index(32'(wr_addr), NUM_REGS);
      rd_kind = decode_kind(32'(rd_addr), NUM_REGS);
      rd_idx  = decode_index(32'(rd_addr), NUM_REGS);
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_cell
         logic sel_value, sel_mode;
         assign sel_value = wr_en && (wr_kind == ADDR_DATA) && (wr_idx == gi);
         assign sel_mode  = wr_en && (wr_kind == ADDR_MODE) && (wr_idx == gi);

         regbank_cell #(
            .DATA_W (DATA_W),
            .STEP   (STEP)
         ) u_cell (
            .clock       (clock),
            .reset       (reset),
            .wr_value_en (sel_value),
            .wr_value    (wr_data),
            .wr_mode_en  (sel_mode),
            .wr_mode     (reg_mode_e'(wr_data[1:0])),
            .tick        (tick),
            .value       (value_arr[gi]),
            .mode        (mode_arr[gi]),
            .wrap        (wrap[gi])
         );

         assign regs_flat[gi*DATA_W +: DATA_W] = value_arr[gi];
      end
   endgenerate

   // Read mux over the current (pre-write, pre-tick) register contents.
   always_comb begin
      rd_sel = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_idx == i) begin
            if (rd_kind == ADDR_DATA)
               rd_sel = value_arr[i];
            else if (rd_kind == ADDR_MODE)
               rd_sel = DATA_W'(mode_arr[i]);
         end
      end
   end

   // Registered read response; data holds between reads, err only flags a live response.
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_valid_reg <= 1'b0;
         rd_data_reg  <= '0;
         rd_err_reg   <= 1'b0;
      end else begin
         rd_valid_reg <= rd_en;
         if (rd_en) begin
            rd_data_reg <= (rd_kind == ADDR_ERR) ? '0 : rd_sel;
            rd_err_reg  <= (rd_kind == ADDR_ERR);
         end else begin
            rd_err_reg  <= 1'b0;
         end
      end
   end

   assign rd_valid = rd_valid_reg;
   assign rd_data  = rd_data_reg;
   assign rd_err   = rd_err_reg;

endmodule

// File: doc/regbank_auto.md
Name: regbank_auto

Overview:
- Parametrised bank of NUM_REGS counter/state registers, each DATA_W bits wide, with a bus write port and a bus read port.
- Each register has a 2-bit mode: hold, increment, decrement or toggle. The mode is applied on every `tick`.
- Wrap events are flagged per register. The full contents are exported as one packed vector for status and debug fan-out.
- Sits alongside the other status/config register blocks; it is the generalised, software-visible successor to fixed free-running status counters.

Parameters:
- NUM_REGS, 2, number of data registers (1..64).
- DATA_W, 32, width of each data register (2..64).
- ADDR_W, 3, bus address width; must satisfy 2**ADDR_W >= 2*NUM_REGS.
- STEP, 1, increment/decrement amount, applied modulo 2**DATA_W.

Ports:
- clock, in, 1, rising-edge clock.
- reset, in, 1, synchronous active-high reset.
- wr_en, in, 1, write strobe.
- wr_addr, in, ADDR_W, write address.
- wr_data, in, DATA_W, write data.
- rd_en, in, 1, read strobe.
- rd_addr, in, ADDR_W, read address.
- rd_valid, out, 1, read response valid.
- rd_data, out, DATA_W, read response data.
- rd_err, out, 1, read address was out of range.
- tick, in, 1, advance enable for all registers.
- wrap, out, NUM_REGS, per-register one-cycle wrap pulse.
- regs_flat, out, NUM_REGS*DATA_W, all data registers; reg i occupies bits [i*DATA_W +: DATA_W].

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. Reset overrides all same-cycle activity, including writes and ticks.
- Reset values: all data registers 0, all modes HOLD, rd_valid 0, rd_data 0, rd_err 0, wrap all 0.
- Address map:
  - 0..NUM_REGS-1: data registers.
  - NUM_REGS..2*NUM_REGS-1: mode register of reg (addr-NUM_REGS). Bits [1:0] hold the mode; upper bits read as 0 and ignore writes.
  - Any address >= 2*NUM_REGS is out of range.
- Modes:
  - HOLD=0: no change.
  - INC=1: reg + STEP.
  - DEC=2: reg - STEP.
  - TOGGLE=3: bitwise invert.
  - Arithmetic is DATA_W-bit modulo.
- Tick: on a tick cycle every register updates per its own mode. Registers update independently.
- Wrap pulse: wrap[i] is asserted in the cycle after the tick that causes the wrap, for exactly one cycle. A wrap is:
  - INC: the unsigned sum overflows 2**DATA_W.
  - DEC: STEP exceeds the current value (borrow).
  - TOGGLE and HOLD never wrap.
- Write vs tick, same register, same cycle: the write wins. No tick update and no wrap for that register. Other registers still tick.
- Mode write plus tick in the same cycle: the tick uses the old mode. The new mode takes effect on the next tick.
- Out-of-range writes are ignored silently.
- Read latency is 1 cycle. rd_valid follows rd_en one cycle later, and rd_data/rd_err are registered.
- Read-during-write to the same address returns the pre-write value (read-old).
- Read-during-tick returns the pre-tick value.
- Out-of-range read: rd_data=0, rd_err=1, rd_valid=1.
- When rd_en=0 in the previous cycle: rd_valid=0, rd_err=0, rd_data holds its last value.
- regs_flat reflects the registered state (zero-latency view of the flops).
- Back-to-back reads every cycle are supported. No stalls; the block never backpressures.

Decomposition:
- Package regbank_auto_pkg contains:
  - enum reg_mode_e {MODE_HOLD, MODE_INC, MODE_DEC, MODE_TOGGLE} (2 bits);
  - packed struct reg_cell_s {mode, value};
  - function for address decode (data vs mode vs error).
- Sub-module regbank_cell: one data register plus its mode register. Inputs: write-value, write-mode strobes and tick. Outputs: value, mode, wrap pulse.
- regbank_auto instantiates NUM_REGS cells in a generate loop and owns the address decode and the read mux.

Test Plan (NUM_REGS=2, DATA_W=32, ADDR_W=3, STEP=1):
- Reset then read addr 0,1,2,3,6.
  - Addrs 0..3: rd_data 0, rd_err 0.
  - Addr 6: rd_err 1.
  - regs_flat = 0.
- Write addr0=0xFFFF_FFFE, addr2=1 (INC), then pulse tick twice.
  - reg0 goes to 0xFFFF_FFFF, then 0x0000_0000.
  - wrap[0]=1 only in the cycle after the second tick.
- Write addr3=2 (DEC) with reg1=0, then tick.
  - reg1=0xFFFF_FFFF, wrap[1] pulses.
  - Then set addr3=3 (TOGGLE), write reg1=0x0000_FFFF, tick: reg1=0xFFFF_0000, no wrap.
- reg0=5 in INC; in one cycle write addr0=0x100 with tick=1 and rd_en on addr0.
  - rd_data=5 next cycle.
  - A later read returns 0x100; no wrap.
- Reset asserted in a cycle with wr_en on addr0=0x55 and tick=1.
  - Next cycle all regs 0, modes HOLD, and wrap, rd_valid and rd_err all 0.
- Write addr5=0xDEAD (out of range), then read addrs 0..3.
  - All values unchanged.
  - rd_valid asserted each cycle with 1-cycle latency on back-to-back reads.
